// File: rtl/conv_ctrl_pkg.sv
// Shared types and size helpers for the image memory frame controller.
// Holds the frame state encoding and the 16-bit memory address type.
package conv_ctrl_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    REQ,
    WAIT,
    WRITE,
    UNLOAD,
    FINISH
  } state_t;

  function automatic int imageBytes(input int bits);
    return bits / 8;
  endfunction

  function automatic int outWords(input int bits);
    return bits / 32;
  endfunction

endpackage

// File: rtl/uno_edge_detect.sv
// Registers the divided Uno link clock and flags its edges.
// Ports: clk, rst_n, unoClk in; rise/fall are 1-cycle pulses.
module uno_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic unoClk,
  output logic rise,
  output logic fall
);

  logic unoPrev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unoPrev <= 1'b0;
    else        unoPrev <= unoClk;
  end

  assign rise = unoClk & ~unoPrev;
  assign fall = ~unoClk & unoPrev;

endmodule

// File: rtl/conv_mem_sequencer.sv
// Frame controller: clear, serial load, per-word engine compute, unload.
// Ports: memory flags/address out, engine start/index, Busy/FrameDone/Error.
import conv_ctrl_pkg::*;

module conv_mem_sequencer #(
  parameter int MaxImageSize = 1280,
  parameter int EngTimeout   = 1023
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        UnoClk,
  input  logic        Go,
  input  logic        EngDone,
  input  logic [15:0] EngReadAddr,
  output logic        MemReset,
  output logic        StartFlag,
  output logic        WriteFlag,
  output logic        DoneFlag,
  output logic [15:0] MemAddress,
  output logic        EngStart,
  output logic [15:0] EngIndex,
  output logic        Busy,
  output logic        FrameDone,
  output logic        Error
);

  localparam int BW = $clog2(MaxImageSize + 1);
  localparam int TW = $clog2(EngTimeout + 1);

  localparam addr_t ImgBytes =
    addr_t'(imageBytes(MaxImageSize));
  localparam logic [15:0] LastWord =
    16'(outWords(MaxImageSize) - 1);
  localparam logic [BW-1:0] LastBit =
    BW'(MaxImageSize - 1);
  localparam logic [TW-1:0] ToLast =
    TW'(EngTimeout - 1);

  state_t        state, stateNext;
  logic [BW-1:0] loadCnt, loadCntNext;
  logic [BW-1:0] bitCnt, bitCntNext;
  logic [15:0]   wordCnt, wordCntNext;
  logic [TW-1:0] toCnt, toCntNext;
  logic          errQ, errNext;
  logic          unoRise, unoFall;

  uno_edge_detect uEdge (
    .clk    (clk),
    .rst_n  (Reset_n),
    .unoClk (UnoClk),
    .rise   (unoRise),
    .fall   (unoFall)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      loadCnt <= '0;
      bitCnt  <= '0;
      wordCnt <= '0;
      toCnt   <= '0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      loadCnt <= loadCntNext;
      bitCnt  <= bitCntNext;
      wordCnt <= wordCntNext;
      toCnt   <= toCntNext;
      errQ    <= errNext;
    end
  end

  always_comb begin
    stateNext   = state;
    loadCntNext = loadCnt;
    bitCntNext  = bitCnt;
    wordCntNext = wordCnt;
    toCntNext   = toCnt;
    errNext     = errQ;
    MemReset    = 1'b0;
    StartFlag   = 1'b0;
    WriteFlag   = 1'b0;
    DoneFlag    = 1'b0;
    MemAddress  = '0;
    EngStart    = 1'b0;
    FrameDone   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Go) begin
          stateNext = CLEAR;
          errNext   = 1'b0;
        end
      end
      CLEAR: begin
        MemReset    = 1'b1;
        loadCntNext = '0;
        stateNext   = LOAD;
      end
      LOAD: begin
        // The exit cycle still has StartFlag high so the
        // memory captures the final bit on that edge.
        StartFlag = 1'b1;
        if (unoRise) begin
          if (loadCnt == LastBit) begin
            loadCntNext = '0;
            wordCntNext = '0;
            stateNext   = REQ;
          end else begin
            loadCntNext = loadCnt + 1'b1;
          end
        end
      end
      REQ: begin
        EngStart  = 1'b1;
        toCntNext = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        MemAddress = EngReadAddr;
        // A done pulse on the final cycle beats the timeout.
        if (EngDone) begin
          stateNext = WRITE;
        end else if (toCnt == ToLast) begin
          errNext   = 1'b1;
          stateNext = FINISH;
        end else begin
          toCntNext = toCnt + 1'b1;
        end
      end
      WRITE: begin
        WriteFlag  = 1'b1;
        MemAddress = ImgBytes + {wordCnt[13:0], 2'b00};
        if (wordCnt == LastWord) begin
          bitCntNext = '0;
          stateNext  = UNLOAD;
        end else begin
          wordCntNext = wordCnt + 1'b1;
          stateNext   = REQ;
        end
      end
      UNLOAD: begin
        // One shift per link period, on its falling edge.
        if (unoFall) begin
          DoneFlag = 1'b1;
          if (bitCnt == LastBit) stateNext = FINISH;
          else bitCntNext = bitCnt + 1'b1;
        end
      end
      FINISH: begin
        FrameDone = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign EngIndex = wordCnt;
  assign Busy     = (state != IDLE);
  assign Error    = errQ;

endmodule

// File: tb/tb_conv_mem_sequencer.sv
// Directed bench for the frame controller (64-bit image, timeout 15).
// Ports: drives clk/UnoClk/Go/engine inputs, observes all outputs.
module tb_conv_mem_sequencer;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        UnoClk = 1'b0;
  logic        Go = 1'b0;
  logic        EngDone = 1'b0;
  logic [15:0] EngReadAddr = 16'd5;
  logic        MemReset, StartFlag, WriteFlag, DoneFlag;
  logic [15:0] MemAddress, EngIndex;
  logic        EngStart, Busy, FrameDone, Error;

  conv_mem_sequencer #(
    .MaxImageSize (64),
    .EngTimeout   (15)
  ) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .UnoClk      (UnoClk),
    .Go          (Go),
    .EngDone     (EngDone),
    .EngReadAddr (EngReadAddr),
    .MemReset    (MemReset),
    .StartFlag   (StartFlag),
    .WriteFlag   (WriteFlag),
    .DoneFlag    (DoneFlag),
    .MemAddress  (MemAddress),
    .EngStart    (EngStart),
    .EngIndex    (EngIndex),
    .Busy        (Busy),
    .FrameDone   (FrameDone),
    .Error       (Error)
  );

  always #5 clk = ~clk;

  // Uno link clock: 4 clk per period, changes just after posedge.
  logic [1:0] unoDiv = 2'd0;
  always @(posedge clk) begin
    #1;
    unoDiv = unoDiv + 2'd1;
    UnoClk = unoDiv[1];
  end

  // Engine model: acks 3 cycles after EngStart when enabled.
  logic engAck = 1'b1;
  always @(negedge clk) begin
    if (EngStart && engAck) begin
      repeat (3) @(posedge clk);
      #1 EngDone = 1'b1;
      @(posedge clk);
      #1 EngDone = 1'b0;
    end
  end

  // Cumulative event monitor.
  int          resetCyc = 0, startRise = 0, doneCnt = 0;
  int          engCnt = 0, wrCnt = 0, fdCnt = 0;
  int          waitCyc = 0, addrErr = 0, flagViol = 0;
  logic        unoPrev = 1'b0, inWait = 1'b0;
  logic [15:0] engIdxLog [64];
  logic [15:0] wrAddrLog [64];

  always @(negedge clk) begin
    assert ($onehot0({MemReset, StartFlag, WriteFlag, DoneFlag}))
    else begin
      flagViol <= flagViol + 1;
      $error("FAIL onehot flags observed=%b expected=onehot0",
             {MemReset, StartFlag, WriteFlag, DoneFlag});
    end
    unoPrev <= UnoClk;
    if (MemReset) resetCyc <= resetCyc + 1;
    if (StartFlag && UnoClk && !unoPrev) startRise <= startRise + 1;
    if ((StartFlag || DoneFlag) && MemAddress != 16'd0)
      addrErr <= addrErr + 1;
    if (DoneFlag) doneCnt <= doneCnt + 1;
    if (EngStart) begin
      engIdxLog[engCnt % 64] <= EngIndex;
      engCnt <= engCnt + 1;
    end
    if (WriteFlag) begin
      wrAddrLog[wrCnt % 64] <= MemAddress;
      wrCnt <= wrCnt + 1;
    end
    if (FrameDone) fdCnt <= fdCnt + 1;
    if (EngStart) inWait <= 1'b1;
    else if (WriteFlag || FrameDone || !Busy) inWait <= 1'b0;
    else if (inWait) begin
      waitCyc <= waitCyc + 1;
      if (MemAddress != EngReadAddr) addrErr <= addrErr + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int sRst, sRise, sDone, sEng, sWr, sFd, sWait, sAddr;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    sRst  = resetCyc;
    sRise = startRise;
    sDone = doneCnt;
    sEng  = engCnt;
    sWr   = wrCnt;
    sFd   = fdCnt;
    sWait = waitCyc;
    sAddr = addrErr;
  endtask

  task automatic waitFrame(input string tag);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (FrameDone === 1'b1) break;
    end
    chk(tag, int'(FrameDone), 1);
    #1;
  endtask

  task automatic outsZero(input string tag);
    chk(tag, int'({MemReset, StartFlag, WriteFlag, DoneFlag,
                   EngStart, Busy, FrameDone, Error}), 0);
    chk({tag, "_addr"}, int'(MemAddress), 0);
    chk({tag, "_idx"}, int'(EngIndex), 0);
  endtask

  task automatic pulseGo();
    @(negedge clk);
    Go = 1'b1;
    @(negedge clk);
    Go = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    outsZero("reset");
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame with a 3-cycle engine.
    snap();
    pulseGo();
    chk("clear_memreset", int'(MemReset), 1);
    chk("clear_busy", int'(Busy), 1);
    @(negedge clk);
    chk("load_start", int'(StartFlag), 1);
    chk("load_addr0", int'(MemAddress), 0);
    waitFrame("frame1_done");
    chk("f1_memreset_cycles", resetCyc - sRst, 1);
    chk("f1_load_bits", startRise - sRise, 64);
    chk("f1_engstarts", engCnt - sEng, 2);
    chk("f1_idx0", int'(engIdxLog[sEng % 64]), 0);
    chk("f1_idx1", int'(engIdxLog[(sEng + 1) % 64]), 1);
    chk("f1_writes", wrCnt - sWr, 2);
    chk("f1_wraddr0", int'(wrAddrLog[sWr % 64]), 8);
    chk("f1_wraddr1", int'(wrAddrLog[(sWr + 1) % 64]), 12);
    chk("f1_wait_cycles", waitCyc - sWait, 6);
    chk("f1_addr_share", addrErr - sAddr, 0);
    chk("f1_doneflags", doneCnt - sDone, 64);
    chk("f1_error", int'(Error), 0);
    @(negedge clk);
    chk("f1_busy_low", int'(Busy), 0);

    // Engine never acks.
    engAck = 1'b0;
    snap();
    pulseGo();
    waitFrame("timeout_done");
    chk("to_wait_cycles", waitCyc - sWait, 15);
    chk("to_writes", wrCnt - sWr, 0);
    chk("to_doneflags", doneCnt - sDone, 0);
    chk("to_error", int'(Error), 1);
    @(negedge clk);
    chk("to_busy_low", int'(Busy), 0);
    chk("to_error_sticky", int'(Error), 1);
    engAck = 1'b1;
    snap();
    pulseGo();
    chk("go_clears_error", int'(Error), 0);
    waitFrame("recover_done");
    chk("rec_doneflags", doneCnt - sDone, 64);
    chk("rec_error", int'(Error), 0);

    // Reset mid-LOAD after 30 bits.
    snap();
    pulseGo();
    begin
      int n = 0;
      while (startRise - sRise < 30 && n < 500) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rst_reach30", startRise - sRise, 30);
    end
    Reset_n = 1'b0;
    #1;
    outsZero("midreset");
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    snap();
    pulseGo();
    chk("rst_clear", int'(MemReset), 1);
    waitFrame("rst_frame_done");
    chk("rst_load_bits", startRise - sRise, 64);
    chk("rst_writes", wrCnt - sWr, 2);
    chk("rst_doneflags", doneCnt - sDone, 64);

    // Go held high through a frame.
    @(negedge clk);
    snap();
    Go = 1'b1;
    @(negedge clk);
    chk("hold_clear", int'(MemReset), 1);
    waitFrame("hold_done");
    chk("hold_one_clear", resetCyc - sRst, 1);
    chk("hold_frames", fdCnt - sFd, 1);
    @(negedge clk);
    chk("hold_idle_busy", int'(Busy), 0);
    chk("hold_idle_memreset", int'(MemReset), 0);
    @(negedge clk);
    chk("hold_restart", int'(MemReset), 1);
    Go = 1'b0;
    waitFrame("hold2_done");

    chk("onehot_violations", flagViol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_mem_sequencer.md
# conv_mem_sequencer

Frame-level controller for the convolution image memory. Sequences one frame through four phases: clear, serial load from the Uno link, convolution compute, serial unload. Drives the memory's Reset/StartFlag/WriteFlag/DoneFlag/MemAddress inputs, and shares the memory address port between itself and the convolution engine. Sits between the top-level start control, the image memory block and the convolution engine.

## Interface
- MaxImageSize, 1280: image size in bits. Must be a multiple of 32.
- EngTimeout, 1023: maximum clk cycles to wait for EngDone before aborting the frame.

- clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- UnoClk  in  1  divided Uno link clock from the memory block, synchronous to clk.
- Go  in  1  frame start request; sampled only in IDLE.
- EngDone  in  1  engine finished the current output word (1-cycle pulse).
- EngReadAddr  in  16  engine's memory byte address while computing.
- MemReset  out  1  drives memory Reset.
- StartFlag  out  1  drives memory StartFlag.
- WriteFlag  out  1  drives memory WriteFlag.
- DoneFlag  out  1  drives memory DoneFlag.
- MemAddress  out  16  drives memory MemAddress.
- EngStart  out  1  1-cycle pulse starting output word EngIndex.
- EngIndex  out  16  output word index 0..OutWords-1.
- Busy  out  1  high in every state except IDLE.
- FrameDone  out  1  1-cycle pulse at frame end.
- Error  out  1  sticky engine-timeout flag; cleared by the next accepted Go.

## Operation
- Derived constants:
  - ImageBytes = MaxImageSize/8.
  - OutWords = MaxImageSize/32.
- States:
  - IDLE: if Go, go to CLEAR and clear Error.
  - CLEAR: MemReset=1 for one cycle, then LOAD.
  - LOAD: StartFlag=1. Count rising UnoClk edges (UnoClk & ~UnoClkPrev). After the MaxImageSize-th edge, set WordCnt=0 and go to REQ.
  - REQ: EngStart=1 with EngIndex=WordCnt, then WAIT.
  - WAIT: MemAddress=EngReadAddr.
    - On EngDone, go to WRITE.
    - If the timeout counter reaches EngTimeout, set Error and go to FINISH.
  - WRITE: WriteFlag=1, MemAddress=ImageBytes+4*WordCnt.
    - If WordCnt=OutWords-1, set BitCnt=0 and go to UNLOAD.
    - Otherwise increment WordCnt and go to REQ.
  - UNLOAD: DoneFlag pulses for one clk on each falling UnoClk edge, so exactly one output bit shifts per link period. After MaxImageSize pulses, go to FINISH.
  - FINISH: FrameDone=1 for one cycle, then IDLE.
- MemAddress is 0 in every state except WAIT and WRITE.
- Invariant: at most one of MemReset/StartFlag/WriteFlag/DoneFlag is high in any cycle. The memory decodes only one-hot flag patterns.
- Go while Busy is ignored.
- EngDone outside WAIT is ignored.
- Counter widths:
  - LoadCnt and BitCnt: $clog2(MaxImageSize+1).
  - WordCnt: 16 bits.
  - Timeout counter: $clog2(EngTimeout+1).
- Address arithmetic is 16-bit unsigned. MaxImageSize must satisfy 2*ImageBytes ≤ 65536.

## Timing
- Reset (Reset_n=0, takes effect immediately): state IDLE; all outputs 0; all counters 0; UnoClkPrev=0.
- Reset mid-frame: aborts at once. The memory is not cleared until the next CLEAR.
- Go accepted at edge t:
  - CLEAR during cycle t+1.
  - LOAD from t+2.
- LOAD exit: the cycle after the MaxImageSize-th rising-edge detect. That cycle's StartFlag is still high, so the memory consumes the final bit.
- Per-word latency: 1 (REQ) + engine latency + 1 (WRITE).
- Timeout counter resets on entry to WAIT. EngDone in the same cycle as the timeout wins (no Error).
- UNLOAD duration: MaxImageSize UnoClk periods, about 50*MaxImageSize clk with the /50 link divider.
- FrameDone fires exactly one cycle before Busy falls.

## Structure
- Package conv_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, REQ, WAIT, WRITE, UNLOAD, FINISH);
  - ImageBytes/OutWords derivation functions;
  - the 16-bit address type.
- One sub-module, uno_edge_detect: registers UnoClk and outputs rise/fall 1-cycle pulses. It has its own async active-low reset.
- The rest is one FSM plus counters, about 200 lines.

## Test plan
Bench uses MaxImageSize=64 (ImageBytes=8, OutWords=2) and EngTimeout=15.

- Full frame: Go, then 64 UnoClk rises, then an engine model acking 3 cycles after EngStart.
  - Required: MemReset for 1 cycle; StartFlag during LOAD; EngIndex 0 then 1.
  - WriteFlag with MemAddress 8, then 12.
  - Exactly 64 DoneFlag pulses, then FrameDone, Busy=0.
- Address sharing: engine drives EngReadAddr=5 in WAIT.
  - Required: MemAddress=5 in WAIT, 0 in LOAD and UNLOAD.
- Timeout: engine never acks.
  - Required: 15 cycles in WAIT, then Error=1, FrameDone, no WriteFlag.
  - Next Go clears Error.
- Reset_n low mid-LOAD after 30 bits.
  - Required: all outputs 0 immediately.
  - A subsequent Go runs a full 64-bit load starting with MemReset.
- Go held high throughout the frame.
  - Required: no restart while Busy; a new frame starts at CLEAR the cycle after returning to IDLE.
- Assertion on every cycle: the four memory flags are never high together (at most one of them high).
